// File: rtl/mips_lsu.sv
// MIPS load/store unit: one memory operation at a time, IDLE -> REQ -> RESP, with bus timeout.
// Optional LSU_ALIGN_EXC_EN: misaligned accesses raise lsu_aexc instead of being force-aligned.
module mips_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_op,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic [31:0] lsu_rdata,
  output logic        lsu_done,
  output logic        lsu_aexc,
  output logic        lsu_berr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          zext_q, zext_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          berr_q, berr_d;

  logic          is_byte, is_half;
  logic          take_exc;
  logic [1:0]    eff_lo;
  logic [3:0]    acc_be;
  logic [31:0]   acc_wdata;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_val;

  assign is_byte = (lsu_op[1:0] == 2'b00);
  assign is_half = (lsu_op[1:0] == 2'b01);

`ifdef LSU_ALIGN_EXC_EN
  logic aexc_q, aexc_d;
  assign take_exc = (is_half & lsu_addr[0]) | (~is_byte & ~is_half & (lsu_addr[1:0] != 2'b00));
  assign eff_lo   = lsu_addr[1:0];
`else
  assign take_exc = 1'b0;
  assign eff_lo   = is_byte ? lsu_addr[1:0] : (is_half ? {lsu_addr[1], 1'b0} : 2'b00);
`endif

  // Lane enables and store-data replication for the operation being accepted.
  always_comb begin
    acc_be    = 4'b1111;
    acc_wdata = lsu_wdata;
    if (is_byte) begin
      acc_be    = 4'b0001 << eff_lo;
      acc_wdata = {4{lsu_wdata[7:0]}};
    end else if (is_half) begin
      acc_be    = eff_lo[1] ? 4'b1100 : 4'b0011;
      acc_wdata = {2{lsu_wdata[15:0]}};
    end
  end

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (lane_q)
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_val = {{24{~zext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{~zext_q & half_sel[15]}}, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    zext_d  = zext_q;
    lane_d  = lane_q;
    rdata_d = rdata_q;
    berr_d  = berr_q;
`ifdef LSU_ALIGN_EXC_EN
    aexc_d  = aexc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (lsu_valid) begin
          we_d    = lsu_we;
          addr_d  = {lsu_addr[31:2], 2'b00};
          be_d    = acc_be;
          wdata_d = acc_wdata;
          size_d  = lsu_op[1:0];
          zext_d  = lsu_op[2];
          lane_d  = eff_lo;
          rdata_d = 32'h0;
          berr_d  = 1'b0;
          cnt_d   = '0;
`ifdef LSU_ALIGN_EXC_EN
          aexc_d  = take_exc;
`endif
          req_d   = ~take_exc;
          state_d = take_exc ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        // An ack on the expiry cycle still completes normally.
        if (mem_ack) begin
          req_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : load_val;
          state_d = S_RESP;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST)) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          rdata_d = 32'h0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      zext_q  <= 1'b0;
      lane_q  <= 2'b00;
      rdata_q <= 32'h0;
      berr_q  <= 1'b0;
`ifdef LSU_ALIGN_EXC_EN
      aexc_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      zext_q  <= zext_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
`ifdef LSU_ALIGN_EXC_EN
      aexc_q  <= aexc_d;
`endif
    end
  end

  assign lsu_ready = (state_q == S_IDLE);
  assign lsu_done  = (state_q == S_RESP);
  assign lsu_rdata = lsu_done ? rdata_q : 32'h0;
  assign lsu_berr  = lsu_done & berr_q;
`ifdef LSU_ALIGN_EXC_EN
  assign lsu_aexc  = lsu_done & aexc_q;
`else
  assign lsu_aexc  = 1'b0;
`endif

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Randomized scoreboard bench for mips_lsu with a bus responder and a response monitor.
`timescale 1ns/1ps
module tb_mips_lsu;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_op = 3'b0;
  logic [31:0] lsu_addr = 32'h0;
  logic [31:0] lsu_wdata = 32'h0;
  logic [31:0] lsu_rdata;
  logic        lsu_done, lsu_aexc, lsu_berr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  mips_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_b(rst_b),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we), .lsu_op(lsu_op),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rdata(lsu_rdata), .lsu_done(lsu_done),
    .lsu_aexc(lsu_aexc), .lsu_berr(lsu_berr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          d;
  } mreq_t;

  typedef struct {
    logic [31:0] rdata;
    logic        aexc;
    logic        berr;
    int          cyc;
  } resp_t;

  mreq_t mq[$];
  resp_t rq[$];
  mreq_t cur;
  int    rc = 0;
  bit    force_ack = 1'b0;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: derive bus request and response from size/offset arithmetic.
  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] rd, input int d, input bit track);
    int unsigned sz, lane, lat;
    logic [31:0] ea, mask, v, exp_wd;
    logic [3:0]  exp_be;
    bit misal, exc, berr;
    int n;
    mreq_t m;
    resp_t r;
    sz    = (op[1:0] == 2'b00) ? 1 : ((op[1:0] == 2'b01) ? 2 : 4);
    misal = (a % sz) != 0;
`ifdef LSU_ALIGN_EXC_EN
    exc = misal;
    ea  = a;
`else
    exc = 1'b0;
    ea  = a - (a % sz);
`endif
    lane   = ea % 4;
    exp_be = 4'(((1 << sz) - 1) << lane);
    exp_wd = (sz == 1) ? w[7:0] * 32'h01010101 : ((sz == 2) ? w[15:0] * 32'h00010001 : w);
    mask   = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
    v      = (rd >> (8 * lane)) & mask;
    if (!op[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    berr = !exc && (d >= TO);
    lat  = exc ? 1 : (berr ? 1 + TO : 2 + d);
    n = 0;
    while (!lsu_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'b0, lsu_ready}, 32'd1);
    lsu_valid = 1'b1;
    lsu_we    = we;
    lsu_op    = op;
    lsu_addr  = a;
    lsu_wdata = w;
    if (!exc) begin
      m.addr = {ea[31:2], 2'b00}; m.be = exp_be; m.we = we; m.wdata = exp_wd;
      m.rdata = rd; m.d = d;
      mq.push_back(m);
    end
    if (track) begin
      r.rdata = (exc || berr || we) ? 32'h0 : v;
      r.aexc  = exc;
      r.berr  = berr;
      r.cyc   = cyc + lat;
      rq.push_back(r);
    end
    @(posedge clk);
    @(negedge clk);
    lsu_valid = 1'b0;
    lsu_addr  = $urandom();
    lsu_wdata = $urandom();
  endtask

  // Bus responder: checks each request against the model and acks after the chosen delay.
  initial begin
    cur = '{addr: 32'h0, be: 4'h0, we: 1'b0, wdata: 32'h0, rdata: 32'h0, d: 0};
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (rc == 0) begin
          if (mq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem_req: got addr %h expected no request", mem_addr);
            cur = '{addr: mem_addr, be: mem_be, we: mem_we, wdata: mem_wdata, rdata: 32'h0, d: 0};
          end else begin
            cur = mq.pop_front();
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_be", {28'b0, mem_be}, {28'b0, cur.be});
            chk("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
            if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
          end
        end else begin
          chk("mem_addr_hold", mem_addr, cur.addr);
          chk("mem_be_hold", {28'b0, mem_be}, {28'b0, cur.be});
        end
        mem_ack   = (rc == cur.d);
        mem_rdata = mem_ack ? cur.rdata : $urandom();
        rc++;
      end else begin
        rc        = 0;
        mem_ack   = force_ack || ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom();
      end
    end
  end

  // Response monitor.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        if (lsu_done) begin
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got lsu_done=1 expected 0 (t=%0t)", $time);
          end else begin
            r = rq.pop_front();
            chk("lsu_rdata", lsu_rdata, r.rdata);
            chk("lsu_aexc", {31'b0, lsu_aexc}, {31'b0, r.aexc});
            chk("lsu_berr", {31'b0, lsu_berr}, {31'b0, r.berr});
            chk("done_cycle", cyc, r.cyc);
          end
        end else begin
          chk("idle_outputs_zero", lsu_rdata | {30'b0, lsu_aexc, lsu_berr}, 32'h0);
        end
      end
    end
  end

  initial begin
    int n;
    #12;
    chk("rst_ready", {31'b0, lsu_ready}, 32'd1);
    chk("rst_done", {31'b0, lsu_done}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    issue(1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'hA1B2_C3D4, 0, 1'b1);
    issue(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, 1'b1);
    issue(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00EE, 32'h0, 0, 1'b1);
    issue(1'b0, 3'b011, 32'h0000_4002, 32'h0, 32'h1357_9BDF, 0, 1'b1);
    issue(1'b0, 3'b011, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 10, 1'b1);
    issue(1'b0, 3'b000, 32'h0000_6001, 32'h0, 32'h0000_8000, 3, 1'b1);
    issue(1'b0, 3'b101, 32'h0000_6002, 32'h0, 32'h8765_4321, 4, 1'b1);
    issue(1'b1, 3'b001, 32'h0000_5003, 32'h1234_BEEF, 32'h0, 2, 1'b1);
    issue(1'b0, 3'b010, 32'h0000_7000, 32'h0, 32'hDEAD_BEEF, 0, 1'b1);
    issue(1'b0, 3'b000, 32'h0000_7002, 32'h0, 32'h0080_0000, 0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom(),
            $urandom(), int'($urandom_range(0, 6)), 1'b1);
    end

    // Reset in the middle of a pending request.
    issue(1'b0, 3'b011, 32'h0000_8000, 32'h0, 32'h0, 50, 1'b0);
    @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("arst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("arst_ready", {31'b0, lsu_ready}, 32'd1);
    chk("arst_done", {31'b0, lsu_done}, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_mem_be", {28'b0, mem_be}, 32'h0);
    chk("arst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("arst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    force_ack = 1'b1;
    repeat (6) @(negedge clk);
    force_ack = 1'b0;
    issue(1'b0, 3'b000, 32'h0000_9002, 32'h0, 32'h0055_0000, 1, 1'b1);

    n = 0;
    while ((rq.size() != 0 || mq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_resp_queue", rq.size(), 32'd0);
    chk("drain_mem_queue", mq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
